// File: rtl/sap_pkg.sv
// rtl/sap_pkg.sv - control word bit map, opcodes and microcode lookup for the SAP core
package sap_pkg;

   localparam int CW_W   = 16;
   localparam int STEP_W = 3;

   localparam int HALT              = 15;
   localparam int MEMORY_ADDRESS_IN = 14;
   localparam int RAM_IN            = 13;
   localparam int RAM_OUT           = 12;
   localparam int INSTR_OUT         = 11;
   localparam int INSTR_IN          = 10;
   localparam int A_IN              = 9;
   localparam int A_OUT             = 8;
   localparam int SUM_OUT           = 7;
   localparam int SUBTRACT          = 6;
   localparam int B_IN              = 5;
   localparam int OUTPUT_IN         = 4;
   localparam int COUNTER_ENABLE    = 3;
   localparam int COUNTER_OUT       = 2;
   localparam int JUMP              = 1;
   localparam int FLAGS_IN          = 0;

   localparam int FLAG_CARRY = 0;
   localparam int FLAG_ZERO  = 1;

   typedef enum logic [3:0] {
      OP_NOP = 4'd0,
      OP_LDA = 4'd1,
      OP_ADD = 4'd2,
      OP_SUB = 4'd3,
      OP_STA = 4'd4,
      OP_LDI = 4'd5,
      OP_JMP = 4'd6,
      OP_JC  = 4'd7,
      OP_JZ  = 4'd8,
      OP_OUT = 4'd14,
      OP_HLT = 4'd15
   } opcode_e;

   // Steps 0 and 1 are the shared fetch; opcodes 9..13 fall to the default and act as NOP.
   function automatic logic [CW_W-1:0] control_word_f(
      input logic [3:0]        opcode,
      input logic [STEP_W-1:0] step,
      input logic [1:0]        flags
   );
      logic [CW_W-1:0] cw;
      cw = '0;
      if (step == 3'd0) begin
         cw[COUNTER_OUT]       = 1'b1;
         cw[MEMORY_ADDRESS_IN] = 1'b1;
      end else if (step == 3'd1) begin
         cw[RAM_OUT]        = 1'b1;
         cw[INSTR_IN]       = 1'b1;
         cw[COUNTER_ENABLE] = 1'b1;
      end else begin
         case (opcode)
            OP_LDA: begin
               if (step == 3'd2) begin
                  cw[INSTR_OUT] = 1'b1; cw[MEMORY_ADDRESS_IN] = 1'b1;
               end else if (step == 3'd3) begin
                  cw[RAM_OUT] = 1'b1; cw[A_IN] = 1'b1;
               end
            end
            OP_ADD, OP_SUB: begin
               if (step == 3'd2) begin
                  cw[INSTR_OUT] = 1'b1; cw[MEMORY_ADDRESS_IN] = 1'b1;
               end else if (step == 3'd3) begin
                  cw[RAM_OUT] = 1'b1; cw[B_IN] = 1'b1;
               end else if (step == 3'd4) begin
                  cw[SUM_OUT]  = 1'b1;
                  cw[A_IN]     = 1'b1;
                  cw[FLAGS_IN] = 1'b1;
                  cw[SUBTRACT] = (opcode == OP_SUB);
               end
            end
            OP_STA: begin
               if (step == 3'd2) begin
                  cw[INSTR_OUT] = 1'b1; cw[MEMORY_ADDRESS_IN] = 1'b1;
               end else if (step == 3'd3) begin
                  cw[A_OUT] = 1'b1; cw[RAM_IN] = 1'b1;
               end
            end
            OP_LDI: begin
               if (step == 3'd2) begin
                  cw[INSTR_OUT] = 1'b1; cw[A_IN] = 1'b1;
               end
            end
            OP_JMP, OP_JC, OP_JZ: begin
               if (step == 3'd2 &&
                   ((opcode == OP_JMP) ||
                    (opcode == OP_JC && flags[FLAG_CARRY]) ||
                    (opcode == OP_JZ && flags[FLAG_ZERO]))) begin
                  cw[INSTR_OUT] = 1'b1; cw[JUMP] = 1'b1;
               end
            end
            OP_OUT: begin
               if (step == 3'd2) begin
                  cw[A_OUT] = 1'b1; cw[OUTPUT_IN] = 1'b1;
               end
            end
            OP_HLT: cw[HALT] = 1'b1;
            default: ;
         endcase
      end
      return cw;
   endfunction

endpackage

// File: rtl/sap_alu.sv
// rtl/sap_alu.sv - 8-bit adder/subtractor with registered {zero, carry} flags
module sap_alu
   import sap_pkg::*;
(
   input  logic       clk,
   input  logic       clear_n,
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic       subtract,
   input  logic       flags_load,
   output logic [7:0] result,
   output logic [1:0] flags
);

   logic [8:0] sum;
   logic [7:0] b_eff;
   logic [1:0] flags_d, flags_q;

   // Subtraction is two's complement: invert b and inject the +1 as carry-in.
   always_comb begin
      b_eff = subtract ? ~b : b;
      sum   = {1'b0, a} + {1'b0, b_eff} + {8'd0, subtract};
   end

   assign result = sum[7:0];

   always_comb begin
      flags_d = flags_q;
      if (flags_load) begin
         flags_d[FLAG_CARRY] = sum[8];
         flags_d[FLAG_ZERO]  = (sum[7:0] == 8'd0);
      end
   end

   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) flags_q <= 2'b00;
      else          flags_q <= flags_d;
   end

   assign flags = flags_q;

endmodule

// File: rtl/sap_control_core.sv
// rtl/sap_control_core.sv - SAP CPU control core: IR, microstep sequencer, PC, ALU and bus drive
module sap_control_core
   import sap_pkg::*;
#(
   parameter int PC_WIDTH = 4,
   parameter int MAX_STEP = 4
) (
   input  logic        clk,
   input  logic        clear_n,
   input  logic [7:0]  a,
   input  logic [7:0]  b,
   input  logic [7:0]  bus_in,
   output logic [7:0]  bus_out,
   output logic        bus_oe,
   output logic [15:0] control_word,
   output logic [1:0]  flags
);

   logic [7:0]          ir_d, ir_q;
   logic [STEP_W-1:0]   step_d, step_q;
   logic [PC_WIDTH-1:0] pc_d, pc_q;
   logic [7:0]          alu_result;
   logic                halt;

   assign control_word = control_word_f(ir_q[7:4], step_q, flags);
   assign halt         = control_word[HALT];

   sap_alu u_alu (
      .clk        (clk),
      .clear_n    (clear_n),
      .a          (a),
      .b          (b),
      .subtract   (control_word[SUBTRACT]),
      .flags_load (control_word[FLAGS_IN] & ~halt),
      .result     (alu_result),
      .flags      (flags)
   );

   // HALT freezes every register, so the control word stays at the halt value until reset.
   always_comb begin
      ir_d   = ir_q;
      step_d = step_q;
      pc_d   = pc_q;
      if (!halt) begin
         step_d = (step_q == STEP_W'(MAX_STEP)) ? '0 : step_q + 3'd1;
         if (control_word[INSTR_IN]) ir_d = bus_in;
         if (control_word[JUMP])                pc_d = bus_in[PC_WIDTH-1:0];
         else if (control_word[COUNTER_ENABLE]) pc_d = pc_q + {{(PC_WIDTH-1){1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         ir_q   <= 8'd0;
         step_q <= '0;
         pc_q   <= '0;
      end else begin
         ir_q   <= ir_d;
         step_q <= step_d;
         pc_q   <= pc_d;
      end
   end

   always_comb begin
      bus_oe  = control_word[SUM_OUT] | control_word[INSTR_OUT] | control_word[COUNTER_OUT];
      bus_out = 8'd0;
      if (control_word[SUM_OUT])          bus_out = alu_result;
      else if (control_word[INSTR_OUT])   bus_out = {4'b0000, ir_q[3:0]};
      else if (control_word[COUNTER_OUT]) bus_out = {{(8-PC_WIDTH){1'b0}}, pc_q};
   end

endmodule

// File: tb/tb_sap_control_core.sv
// tb/tb_sap_control_core.sv - directed program run against an instruction-level model of the SAP core
module tb_sap_control_core;

   logic        clk = 1'b0;
   logic        clear_n;
   logic [7:0]  a, b, bus_in;
   logic [7:0]  bus_out;
   logic        bus_oe;
   logic [15:0] control_word;
   logic [1:0]  flags;

   int checks = 0;
   int errors = 0;

   logic [15:0] obs_cw [5];
   logic [7:0]  obs_bus [5];

   always #5 clk = ~clk;

   sap_control_core #(.PC_WIDTH(4), .MAX_STEP(4)) dut (
      .clk          (clk),
      .clear_n      (clear_n),
      .a            (a),
      .b            (b),
      .bus_in       (bus_in),
      .bus_out      (bus_out),
      .bus_oe       (bus_oe),
      .control_word (control_word),
      .flags        (flags)
   );

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   int m_pc = 0, m_ir = 0, m_step = 0, m_c = 0, m_z = 0;

   function automatic logic [15:0] m_cw_f(input int ir, input int step, input int c, input int z);
      if (step == 0) return 16'h4004;
      if (step == 1) return 16'h1408;
      case (ir / 16)
         1:  return (step == 2) ? 16'h4800 : (step == 3) ? 16'h1200 : 16'h0000;
         2:  return (step == 2) ? 16'h4800 : (step == 3) ? 16'h1020 : 16'h0281;
         3:  return (step == 2) ? 16'h4800 : (step == 3) ? 16'h1020 : 16'h02C1;
         4:  return (step == 2) ? 16'h4800 : (step == 3) ? 16'h2100 : 16'h0000;
         5:  return (step == 2) ? 16'h0A00 : 16'h0000;
         6:  return (step == 2) ? 16'h0802 : 16'h0000;
         7:  return (step == 2 && c == 1) ? 16'h0802 : 16'h0000;
         8:  return (step == 2 && z == 1) ? 16'h0802 : 16'h0000;
         14: return (step == 2) ? 16'h0110 : 16'h0000;
         15: return 16'h8000;
         default: return 16'h0000;
      endcase
   endfunction

   logic [15:0] m_cw;
   int          m_sum, m_res, m_carry;
   logic [7:0]  m_bus;
   logic        m_oe;

   always_comb begin
      m_cw = m_cw_f(m_ir, m_step, m_c, m_z);
      if (m_cw[6]) begin
         m_sum   = int'(a) - int'(b);
         m_carry = (a >= b) ? 1 : 0;
      end else begin
         m_sum   = int'(a) + int'(b);
         m_carry = (m_sum > 255) ? 1 : 0;
      end
      m_res = m_sum & 255;
      m_oe  = m_cw[7] | m_cw[11] | m_cw[2];
      if (m_cw[7])       m_bus = 8'(m_res);
      else if (m_cw[11]) m_bus = 8'(m_ir % 16);
      else if (m_cw[2])  m_bus = 8'(m_pc);
      else               m_bus = 8'h00;
   end

   always @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         m_pc <= 0; m_ir <= 0; m_step <= 0; m_c <= 0; m_z <= 0;
      end else if (m_cw != 16'h8000) begin
         m_step <= (m_step + 1) % 5;
         if (m_cw[10]) m_ir <= int'(bus_in);
         if (m_cw[1])      m_pc <= int'(bus_in) % 16;
         else if (m_cw[3]) m_pc <= (m_pc + 1) % 16;
         if (m_cw[0]) begin
            m_c <= m_carry;
            m_z <= (m_res == 0) ? 1 : 0;
         end
      end
   end

   always @(negedge clk) begin
      check("cw", control_word, m_cw);
      check("bus_oe", 16'(bus_oe), 16'(m_oe));
      check("bus_out", 16'(bus_out), 16'(m_bus));
      check("flags", 16'(flags), 16'({m_z[0], m_c[0]}));
   end

   task automatic run_instr(input logic [7:0] op, input logic [7:0] mem,
                            input logic [7:0] av, input logic [7:0] bv);
      for (int s = 0; s < 5; s++) begin
         a = av;
         b = bv;
         #1;
         bus_in = bus_oe ? bus_out : ((s == 1) ? op : mem);
         #2;
         obs_cw[s]  = control_word;
         obs_bus[s] = bus_out;
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      clear_n = 1'b0;
      a = 8'h00; b = 8'h00; bus_in = 8'h00;
      repeat (2) @(posedge clk);
      #1;
      check("rst_cw", control_word, 16'h4004);
      check("rst_bus_out", 16'(bus_out), 16'h0000);
      check("rst_bus_oe", 16'(bus_oe), 16'h0001);
      check("rst_flags", 16'(flags), 16'h0000);
      clear_n = 1'b1;

      run_instr(8'h1E, 8'h33, 8'h00, 8'h00);
      check("fetch0_cw", obs_cw[0], 16'h4004);
      check("fetch0_pc", 16'(obs_bus[0]), 16'h0000);
      check("fetch1_cw", obs_cw[1], 16'h1408);
      check("lda_operand", 16'(obs_bus[2]), 16'h000E);

      run_instr(8'h57, 8'h00, 8'h00, 8'h00);
      check("pc_after_fetch", 16'(obs_bus[0]), 16'h0001);
      check("ldi_s2_cw", obs_cw[2], 16'h0A00);
      check("ldi_s2_bus", 16'(obs_bus[2]), 16'h0007);
      check("ldi_s3_cw", obs_cw[3], 16'h0000);
      check("ldi_s4_cw", obs_cw[4], 16'h0000);

      run_instr(8'h2F, 8'h01, 8'hFF, 8'h01);
      check("step_wrap_cw", obs_cw[0], 16'h4004);
      check("add_s4_cw", obs_cw[4], 16'h0281);
      check("add_s4_bus", 16'(obs_bus[4]), 16'h0000);
      check("add_flags", 16'(flags), 16'h0003);

      run_instr(8'h3F, 8'h05, 8'h05, 8'h05);
      check("sub_eq_bus", 16'(obs_bus[4]), 16'h0000);
      check("sub_eq_flags", 16'(flags), 16'h0003);

      run_instr(8'h3F, 8'h05, 8'h03, 8'h05);
      check("sub_neg_bus", 16'(obs_bus[4]), 16'h00FE);
      check("sub_neg_flags", 16'(flags), 16'h0000);

      run_instr(8'h7A, 8'h00, 8'h00, 8'h00);
      check("jc_nc_cw", obs_cw[2], 16'h0000);

      run_instr(8'h3F, 8'h03, 8'h05, 8'h03);
      check("jc_nc_pc", 16'(obs_bus[0]), 16'h0006);
      check("sub_pos_flags", 16'(flags), 16'h0001);

      run_instr(8'h7A, 8'h00, 8'h00, 8'h00);
      check("jc_c_cw", obs_cw[2], 16'h0802);
      check("jc_c_bus", 16'(obs_bus[2]), 16'h000A);

      run_instr(8'h8C, 8'h00, 8'h00, 8'h00);
      check("jc_target_pc", 16'(obs_bus[0]), 16'h000A);
      check("jz_nz_cw", obs_cw[2], 16'h0000);

      run_instr(8'h2F, 8'h00, 8'h00, 8'h00);
      check("add_zero_flags", 16'(flags), 16'h0002);

      run_instr(8'h8F, 8'h00, 8'h00, 8'h00);
      check("jz_z_cw", obs_cw[2], 16'h0802);

      run_instr(8'h00, 8'h00, 8'h00, 8'h00);
      check("nop_at_f_pc", 16'(obs_bus[0]), 16'h000F);

      run_instr(8'hE0, 8'h00, 8'h42, 8'h00);
      check("pc_wrap", 16'(obs_bus[0]), 16'h0000);
      check("out_cw", obs_cw[2], 16'h0110);

      run_instr(8'h4E, 8'h00, 8'h42, 8'h00);
      check("sta_s3_cw", obs_cw[3], 16'h2100);

      run_instr(8'h93, 8'h00, 8'h00, 8'h00);
      check("op9_s2_cw", obs_cw[2], 16'h0000);
      check("op9_s3_cw", obs_cw[3], 16'h0000);

      run_instr(8'h63, 8'h00, 8'h00, 8'h00);
      check("jmp_cw", obs_cw[2], 16'h0802);

      run_instr(8'hF0, 8'h00, 8'h00, 8'h00);
      check("hlt_pc", 16'(obs_bus[0]), 16'h0003);
      check("hlt_s2_cw", obs_cw[2], 16'h8000);
      check("hlt_s4_cw", obs_cw[4], 16'h8000);
      repeat (20) @(posedge clk);
      #1;
      check("hlt_hold_cw", control_word, 16'h8000);
      check("hlt_hold_oe", 16'(bus_oe), 16'h0000);

      #1;
      clear_n = 1'b0;
      #1;
      check("async_rst_cw", control_word, 16'h4004);
      check("async_rst_bus", 16'(bus_out), 16'h0000);
      @(posedge clk);
      #1;
      clear_n = 1'b1;

      run_instr(8'h55, 8'h00, 8'h00, 8'h00);
      check("restart_pc", 16'(obs_bus[0]), 16'h0000);
      check("restart_ldi_cw", obs_cw[2], 16'h0A00);
      check("restart_ldi_bus", 16'(obs_bus[2]), 16'h0005);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
